// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
// Optional build macro FWD_ZERO_REG_EN (hardwired-zero register 0) is honoured in fwd_tag_cmp.
package fwd_pkg;

   // Widest register tag any instance may use; stage tags are stored zero-extended to this width
   localparam int MAX_REG_W = 8;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_WB  = 2'b01;
   localparam fwd_sel_t FWD_MEM = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic                 wr;
      logic                 is_load;
      logic [MAX_REG_W-1:0] dst;
   } stage_tag_t;

   localparam stage_tag_t STAGE_BUBBLE = '0;

   // A read operand depends on a stage when that stage holds a real writer of the same register
   function automatic logic tag_match(input logic [MAX_REG_W-1:0] src,
                                      input logic                 used,
                                      input stage_tag_t           stage);
      return used & stage.valid & stage.wr & (src == stage.dst);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and hazard-response bundle for fwd_hazard_unit.
// master = pipeline control driving ID information, slave = the hazard unit.
interface fwd_hazard_unit_if #(
   parameter int NUM_SRC  = 2,
   parameter int NUM_REGS = 8
);
   localparam int REG_W = $clog2(NUM_REGS);

   logic                     id_valid;
   logic [NUM_SRC*REG_W-1:0] id_src;
   logic [NUM_SRC-1:0]       id_src_used;
   logic [REG_W-1:0]         id_dst;
   logic                     id_wr;
   logic                     id_is_load;
   logic                     hold;
   logic                     flush;

   logic                     stall_id;
   logic [2*NUM_SRC-1:0]     ex_fwd_sel;
   logic [NUM_SRC-1:0]       id_wb_bypass;
   logic                     ex_valid;
   logic                     mem_valid;
   logic                     wb_valid;

   modport master (
      output id_valid, id_src, id_src_used, id_dst, id_wr, id_is_load, hold, flush,
      input  stall_id, ex_fwd_sel, id_wb_bypass, ex_valid, mem_valid, wb_valid
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_dst, id_wr, id_is_load, hold, flush,
      output stall_id, ex_fwd_sel, id_wb_bypass, ex_valid, mem_valid, wb_valid
   );

endinterface

// File: rtl/fwd_tag_cmp.sv
// Single-operand comparator of one source tag against one shadow-stage tag.
// With FWD_ZERO_REG_EN defined, register 0 is hardwired zero and never matches.
module fwd_tag_cmp
   import fwd_pkg::*;
#(
   parameter int REG_W = 3
) (
   input  logic [REG_W-1:0] i_src,
   input  logic             i_used,
   input  stage_tag_t       i_stage,
   output logic             o_match
);

   logic w_rawMatch;
   logic w_unusedLoadFlag;

   assign w_rawMatch       = tag_match(MAX_REG_W'(i_src), i_used, i_stage);
   assign w_unusedLoadFlag = i_stage.is_load;

`ifdef FWD_ZERO_REG_EN
   assign o_match = w_rawMatch & (i_src != '0);
`else
   assign o_match = w_rawMatch;
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Tracks destination tags of in-flight instructions (EX, MEM, WB), registers per-operand
// forward selects one cycle ahead of EX, raises a one-cycle load-use stall and flags
// regfile write-through bypass in ID. Build macro FWD_ZERO_REG_EN makes register 0 hardwired zero.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int NUM_REGS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   fwd_hazard_unit_if.slave   bus
);

   localparam int REG_W = $clog2(NUM_REGS);

   stage_tag_t               r_ex;
   stage_tag_t               r_mem;
   stage_tag_t               r_wb;
   logic [2*NUM_SRC-1:0]     r_fwdSel;

   logic [NUM_SRC-1:0]       w_matchEx;
   logic [NUM_SRC-1:0]       w_matchMem;
   logic [NUM_SRC-1:0]       w_matchWb;
   logic                     w_stall;
   logic                     w_bubble;
   stage_tag_t               w_exNext;
   logic [2*NUM_SRC-1:0]     w_fwdSelNext;

   // Every operand is compared against each of the three shadow stages
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_tag_cmp #(.REG_W(REG_W)) u_cmpEx (
         .i_src   (bus.id_src[g*REG_W +: REG_W]),
         .i_used  (bus.id_src_used[g]),
         .i_stage (r_ex),
         .o_match (w_matchEx[g])
      );

      fwd_tag_cmp #(.REG_W(REG_W)) u_cmpMem (
         .i_src   (bus.id_src[g*REG_W +: REG_W]),
         .i_used  (bus.id_src_used[g]),
         .i_stage (r_mem),
         .o_match (w_matchMem[g])
      );

      fwd_tag_cmp #(.REG_W(REG_W)) u_cmpWb (
         .i_src   (bus.id_src[g*REG_W +: REG_W]),
         .i_used  (bus.id_src_used[g]),
         .i_stage (r_wb),
         .o_match (w_matchWb[g])
      );

      // The stall guarantees a load never sits in MEM while its consumer is told to take MEM data
      a_noMemLoadFwd : assert property (@(posedge clk) disable iff (!rst_n)
         (r_fwdSel[2*g +: 2] == FWD_MEM) |-> !r_mem.is_load);
   end

   // A load in EX cannot supply data yet; a flush kills the consumer so no stall is needed then
   assign w_stall  = bus.id_valid & ~bus.flush & (|w_matchEx) & r_ex.is_load;
   assign w_bubble = bus.flush | w_stall | ~bus.id_valid;

   // Tag the instruction leaving ID, or a bubble when it is killed, stalled or absent
   always_comb begin
      w_exNext = STAGE_BUBBLE;
      if (!w_bubble) begin
         w_exNext.valid   = 1'b1;
         w_exNext.wr      = bus.id_wr;
         w_exNext.is_load = bus.id_is_load;
         w_exNext.dst     = MAX_REG_W'(bus.id_dst);
      end
   end

   // Pick the youngest producer for each operand one cycle before the consumer reaches EX
   always_comb begin
      w_fwdSelNext = '0;
      if (!w_bubble) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_matchEx[i] && !r_ex.is_load) begin
               w_fwdSelNext[2*i +: 2] = FWD_MEM;
            end else if (w_matchMem[i]) begin
               w_fwdSelNext[2*i +: 2] = FWD_WB;
            end else begin
               w_fwdSelNext[2*i +: 2] = FWD_RF;
            end
         end
      end
   end

   // Advance the shadow pipeline and the registered selects unless the whole core is held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex     <= STAGE_BUBBLE;
         r_mem    <= STAGE_BUBBLE;
         r_wb     <= STAGE_BUBBLE;
         r_fwdSel <= '0;
      end else if (!bus.hold) begin
         r_wb     <= r_mem;
         r_mem    <= r_ex;
         r_ex     <= w_exNext;
         r_fwdSel <= w_fwdSelNext;
      end
   end

   assign bus.stall_id     = w_stall;
   assign bus.ex_fwd_sel   = r_fwdSel;
   assign bus.id_wb_bypass = w_matchWb;
   assign bus.ex_valid     = r_ex.valid;
   assign bus.mem_valid    = r_mem.valid;
   assign bus.wb_valid     = r_wb.valid;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (NUM_SRC=2, NUM_REGS=8).
// Reference model keeps the last three issued slots by age and resolves hazards by distance.
// Honours FWD_ZERO_REG_EN the same way the design does.
module tb_fwd_hazard_unit;

   localparam int NS = 2;
   localparam int NR = 8;
   localparam int RW = 3;

   logic clk;
   logic rst_n;

   fwd_hazard_unit_if #(.NUM_SRC(NS), .NUM_REGS(NR)) ifc ();

   fwd_hazard_unit #(.NUM_SRC(NS), .NUM_REGS(NR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit valid;
      bit wr;
      bit ld;
      int dst;
   } slot_t;

   // inflight[d] is the instruction issued d cycles ago (1 = EX, 2 = MEM, 3 = WB)
   slot_t inflight [1:3];
   int    expSel   [NS];
   bit    zeroReg;

   int    curSrc   [NS];
   bit    curUsed  [NS];
   bit    curV;
   bit    curFlush;

   // Free-running core clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit srcHits(input int src, input bit used, input slot_t s);
      if (zeroReg && src == 0) return 1'b0;
      return used && s.valid && s.wr && (s.dst == src);
   endfunction

   function automatic bit modelStall();
      bit any;
      any = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (srcHits(curSrc[i], curUsed[i], inflight[1]) && inflight[1].ld) any = 1'b1;
      end
      return any && curV && !curFlush;
   endfunction

   task automatic resetModel();
      for (int d = 1; d <= 3; d++) inflight[d] = '{valid: 1'b0, wr: 1'b0, ld: 1'b0, dst: 0};
      for (int i = 0; i < NS; i++) expSel[i] = 0;
   endtask

   // Present one ID instruction for a cycle, check every output, then follow the clock edge
   task automatic applyStimulus(input bit v, input int s0, input int s1, input bit u0, input bit u1,
                                input int dst, input bit wr, input bit ld, input bit hold,
                                input bit flush);
      bit             stall;
      bit             bubble;
      logic [NS-1:0]  expBy;
      logic [2*NS-1:0] expVec;
      logic [1:0]     selBits;
      int             newSel [NS];

      curV = v; curFlush = flush;
      curSrc[0] = s0; curSrc[1] = s1;
      curUsed[0] = u0; curUsed[1] = u1;

      ifc.id_valid    = v;
      ifc.id_src      = {RW'(s1), RW'(s0)};
      ifc.id_src_used = {u1, u0};
      ifc.id_dst      = RW'(dst);
      ifc.id_wr       = wr;
      ifc.id_is_load  = ld;
      ifc.hold        = hold;
      ifc.flush       = flush;
      #1;

      stall = modelStall();
      for (int i = 0; i < NS; i++) begin
         expBy[i] = srcHits(curSrc[i], curUsed[i], inflight[3]);
         selBits  = 2'(expSel[i]);
         expVec[2*i +: 2] = selBits;
      end
      checkOutput("stall_id",     32'(ifc.stall_id),     32'(stall));
      checkOutput("id_wb_bypass", 32'(ifc.id_wb_bypass), 32'(expBy));
      checkOutput("ex_fwd_sel",   32'(ifc.ex_fwd_sel),   32'(expVec));
      checkOutput("ex_valid",     32'(ifc.ex_valid),     32'(inflight[1].valid));
      checkOutput("mem_valid",    32'(ifc.mem_valid),    32'(inflight[2].valid));
      checkOutput("wb_valid",     32'(ifc.wb_valid),     32'(inflight[3].valid));

      @(posedge clk);
      if (!hold) begin
         bubble = flush || stall || !v;
         for (int i = 0; i < NS; i++) begin
            if (bubble)                                           newSel[i] = 0;
            else if (srcHits(curSrc[i], curUsed[i], inflight[1])) newSel[i] = 2;
            else if (srcHits(curSrc[i], curUsed[i], inflight[2])) newSel[i] = 1;
            else                                                  newSel[i] = 0;
         end
         for (int i = 0; i < NS; i++) expSel[i] = newSel[i];
         inflight[3] = inflight[2];
         inflight[2] = inflight[1];
         if (bubble) inflight[1] = '{valid: 1'b0, wr: 1'b0, ld: 1'b0, dst: 0};
         else        inflight[1] = '{valid: 1'b1, wr: wr, ld: ld, dst: dst};
      end
      @(negedge clk);
   endtask

   // Asynchronous reset pulse landing between clock edges
   task automatic pulseReset();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_ex_valid",  32'(ifc.ex_valid),   32'd0);
      checkOutput("rst_mem_valid", 32'(ifc.mem_valid),  32'd0);
      checkOutput("rst_wb_valid",  32'(ifc.wb_valid),   32'd0);
      checkOutput("rst_fwd_sel",   32'(ifc.ex_fwd_sel), 32'd0);
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
`ifdef FWD_ZERO_REG_EN
      zeroReg = 1'b1;
`else
      zeroReg = 1'b0;
`endif
      rst_n = 1'b0;
      ifc.id_valid = 1'b0; ifc.id_src = '0; ifc.id_src_used = '0; ifc.id_dst = '0;
      ifc.id_wr = 1'b0; ifc.id_is_load = 1'b0; ifc.hold = 1'b0; ifc.flush = 1'b0;
      resetModel();
      #2;
      checkOutput("reset_stall",   32'(ifc.stall_id),   32'd0);
      checkOutput("reset_sel",     32'(ifc.ex_fwd_sel), 32'd0);
      checkOutput("reset_valids",  32'({ifc.ex_valid, ifc.mem_valid, ifc.wb_valid}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] back-to-back ALU forward");
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      applyStimulus(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
      checkOutput("t1_sel", 32'(ifc.ex_fwd_sel), 32'h2);

      $display("[TB] gap of one and two");
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);
      checkOutput("t2_sel_gap1", 32'(ifc.ex_fwd_sel), 32'h4);
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5, 3, 1, 1, 6, 1, 0, 1, 0);
      checkOutput("t2_bypass_gap2", 32'(ifc.id_wb_bypass), 32'h2);
      applyStimulus(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);
      checkOutput("t2_sel_gap2", 32'(ifc.ex_fwd_sel), 32'h0);

      $display("[TB] load-use stall");
      applyStimulus(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      applyStimulus(1, 2, 2, 1, 1, 5, 1, 0, 1, 0);
      checkOutput("t3_stall_in_hold", 32'(ifc.stall_id), 32'd1);
      applyStimulus(1, 2, 2, 1, 1, 5, 1, 0, 0, 0);
      checkOutput("t3_bubble", 32'(ifc.ex_valid), 32'd0);
      checkOutput("t3_stall_once", 32'(ifc.stall_id), 32'd0);
      applyStimulus(1, 2, 2, 1, 1, 5, 1, 0, 0, 0);
      checkOutput("t3_sel", 32'(ifc.ex_fwd_sel), 32'h5);

      $display("[TB] flush during load-use");
      applyStimulus(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      applyStimulus(1, 2, 2, 1, 1, 5, 1, 0, 0, 1);
      checkOutput("t4_bubble", 32'(ifc.ex_valid), 32'd0);
      checkOutput("t4_sel", 32'(ifc.ex_fwd_sel), 32'h0);

      $display("[TB] hold mid-forward and async reset");
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      applyStimulus(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, $urandom_range(0, 7), $urandom_range(0, 7), 1, 1,
                       $urandom_range(0, 7), 1, 0, 1, 0);
         checkOutput("t5_hold_sel", 32'(ifc.ex_fwd_sel), 32'h2);
         checkOutput("t5_hold_valids", 32'({ifc.ex_valid, ifc.mem_valid}), 32'h3);
      end
      applyStimulus(1, 4, 3, 1, 1, 7, 1, 0, 0, 0);
      checkOutput("t5_resume_sel", 32'(ifc.ex_fwd_sel), 32'h6);
      pulseReset();

      $display("[TB] register zero");
      applyStimulus(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 0, 4, 1, 0, 0, 0);
      checkOutput("t6_sel", 32'(ifc.ex_fwd_sel), zeroReg ? 32'h0 : 32'h2);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      applyStimulus(1, 0, 0, 1, 1, 4, 1, 0, 0, 0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) pulseReset();
         applyStimulus($urandom_range(0, 4) != 0,
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the 5-stage pipeline. It generalises the combinational EX-stage forwarding compare to NUM_SRC source operands and NUM_REGS registers. It tracks the destination tags of in-flight instructions in its own shadow pipeline (EX, MEM, WB). It produces registered per-operand forward selects aligned to the EX stage, a one-cycle load-use stall, and ID-stage write-through bypass flags, with hold and flush handling.

Parameters:
NUM_SRC, 2, number of source operands per instruction (1..4)
NUM_REGS, 8, architectural register count (power of two, >=2)
REG_W, $clog2(NUM_REGS), register tag width (derived; not overridden)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_src  in  NUM_SRC*REG_W  source tags; operand i at [i*REG_W +: REG_W]
id_src_used  in  NUM_SRC  operand i is actually read
id_dst  in  REG_W  destination tag
id_wr  in  1  instruction writes id_dst
id_is_load  in  1  instruction is a load
hold  in  1  global freeze (memory wait); all state holds
flush  in  1  kill instruction in ID (taken branch/jump resolved in EX)
stall_id  out  1  load-use stall; freeze IF/ID, inject bubble into EX
ex_fwd_sel  out  2*NUM_SRC  per operand in EX: 2'b00 regfile/latched, 2'b01 from WB, 2'b10 from MEM, 2'b11 never driven
id_wb_bypass  out  NUM_SRC  operand i in ID must take WB write data (regfile write-through)
ex_valid, mem_valid, wb_valid  out  1 each  shadow-pipeline occupancy (debug/verification)

Behaviour:
- Shadow pipeline: each stage holds {valid, wr, is_load, dst}.
- match(i, S) = id_src_used[i] & S.valid & S.wr & (src_i == S.dst).
- stall_id (combinational) = id_valid & !flush & OR_i(match(i, EX) & EX.is_load). It is computed during hold too.
- On each clk edge with hold=0:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble (all zero) if flush | stall_id | !id_valid; otherwise {1, id_wr, id_is_load, id_dst}.
  - ex_fwd_sel[i] <= 2'b00 if bubble is injected.
  - Otherwise ex_fwd_sel[i] <= 2'b10 if match(i, EX) & !EX.is_load; else 2'b01 if match(i, MEM); else 2'b00.
  - MEM has priority over WB (youngest producer wins).
- Selects are computed one cycle early, so ex_fwd_sel has zero combinational path from id_* to EX. Latency is 1 cycle from ID presentation.
- A load in EX matched by ID always stalls exactly one cycle. On the next cycle the load is in MEM and the bubble is in EX. The consumer then registers 2'b01 and reads the load data from WB when it reaches EX.
- A load in MEM never yields 2'b10 (guaranteed by the stall); an assertion checks this.
- id_wb_bypass[i] = match(i, WB). It is combinational and independent of hold and flush.
- hold=1: every register holds its value, including ex_fwd_sel. Only the combinational outputs track their inputs.
- flush and stall together: flush wins. stall_id=0 and a bubble is injected.
- A source matching multiple stages resolves by priority. A source matching an EX non-writer is ignored.
- id_valid=0: stall_id=0 and a bubble enters EX.
- Reset (rst_n low, any time, asynchronous): all stage valids 0, ex_fwd_sel all 00, stall_id 0 (no valid EX load exists). On release, the first edge behaves as normal.

Optional Feature:
FWD_ZERO_REG_EN
- Defined: tag 0 is hardwired zero. match() is forced false whenever src_i==0, so no forward, stall or bypass is ever generated for register 0.
- Undefined: register 0 is an ordinary register (WISC default).

Decomposition:
- Shared package fwd_pkg:
  - typedef fwd_sel_t (2-bit) with constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - typedef stage_tag_t {valid, wr, is_load, dst}.
  - Helper function tag_match.
- One natural sub-module, fwd_tag_cmp: a single-operand comparator against one stage tag, honouring FWD_ZERO_REG_EN. It is instantiated NUM_SRC x 3 times via generate.

Test Plan:
1. Back-to-back ALU, NUM_REGS=8:
   - Stimulus: ADD r3 then SUB r4,r3,r1.
   - Required: cycle after SUB enters EX, ex_fwd_sel[1:0]=10, operand1=00, stall_id=0.
2. Gap of one:
   - Stimulus: ADD r3, NOP, consumer of r3 on src1.
   - Required: ex_fwd_sel[3:2]=01. With gap of two: id_wb_bypass[1]=1 and sel=00.
3. Load-use:
   - Stimulus: LD r2 then ADD r5,r2,r2.
   - Required: stall_id=1 for exactly one cycle, EX bubble (ex_valid=0), then ex_fwd_sel=0101.
4. Flush during stall:
   - Stimulus: load-use condition plus flush=1.
   - Required: stall_id=0, EX bubble, next ex_fwd_sel=0000.
5. Hold:
   - Stimulus: assert hold 3 cycles mid-forward.
   - Required: ex_fwd_sel and valids unchanged, then resume with the correct sequence. Async rst_n pulse mid-stream clears all valids and selects immediately.
6. FWD_ZERO_REG_EN:
   - Stimulus: ADD r0, then a consumer of r0.
   - Required: with the macro defined, sel=00 and no stall after LD r0. Without it, sel=10.
